// File: rtl/req_ack_fifo_pkg.sv
// req_ack_fifo_pkg: shared widths for the req/ack elastic buffer
package req_ack_fifo_pkg;
  localparam int data_width_default = 32;
  localparam int count_width = 32;
endpackage

// File: rtl/req_ack_fifo_mem.sv
// req_ack_fifo_mem: depth x data_width register array with one synchronous write and one combinational read port
//   clk       clock
//   we/wa/wd  write enable, write address, write data (captured on posedge)
//   ra/rd     read address and combinational read data
module req_ack_fifo_mem
  import req_ack_fifo_pkg::*;
#(
  parameter int data_width = data_width_default,
  parameter int depth = 8,
  parameter int addr_width = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] wa,
  input  logic [data_width-1:0] wd,
  input  logic [addr_width-1:0] ra,
  output logic [data_width-1:0] rd
);
  logic [data_width-1:0] mem [depth];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/req_ack_fifo.sv
// req_ack_fifo: elastic buffer between a req/ack responder upstream and a req/ack requester downstream
//   clk, rst            clock, synchronous active-high reset
//   up_req/up_ack/up_din    requester side: raise up_req, capture up_din on the up_ack pulse
//   dn_req/dn_ack/dn_dout   responder side: answer dn_req with a 1-cycle dn_ack and data
//   level/full/empty        occupancy 0..depth and its decodes
//   count_in/count_out      accepted writes / completed reads since reset
//   proto_err               sticky: up_ack arrived with no request outstanding
module req_ack_fifo
  import req_ack_fifo_pkg::*;
#(
  parameter int data_width = data_width_default,
  parameter int depth = 8,
  parameter int addr_width = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   up_req,
  input  logic                   up_ack,
  input  logic [data_width-1:0]  up_din,
  input  logic                   dn_req,
  output logic                   dn_ack,
  output logic [data_width-1:0]  dn_dout,
  output logic [addr_width:0]    level,
  output logic                   full,
  output logic                   empty,
  output logic [count_width-1:0] count_in,
  output logic [count_width-1:0] count_out,
  output logic                   proto_err
);
  localparam logic [addr_width:0] depth_l = (addr_width+1)'(depth);
  logic [addr_width-1:0] wr_ptr, rd_ptr;
  logic [data_width-1:0] rd_data;
  logic wr, rd, has_room;
  always_comb begin
    wr = up_ack & up_req;
    // read decision uses the pre-edge level, and a fresh dn_ack blocks back-to-back reads
    rd = dn_req & ~dn_ack & ~empty;
    has_room = level < depth_l;
    full = level == depth_l;
    empty = level == '0;
  end
  req_ack_fifo_mem #(
    .data_width(data_width),
    .depth(depth),
    .addr_width(addr_width)
  ) u_mem (
    .clk(clk),
    .we(wr & ~rst),
    .wa(wr_ptr),
    .wd(up_din),
    .ra(rd_ptr),
    .rd(rd_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      up_req <= 1'b0;
      dn_ack <= 1'b0;
      dn_dout <= '0;
      level <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count_in <= '0;
      count_out <= '0;
      proto_err <= 1'b0;
    end else begin
      // only one request is ever outstanding and it is only raised with room left,
      // so a write can never land on a full buffer
      if (wr) begin
        wr_ptr <= wr_ptr + addr_width'(1);
        count_in <= count_in + count_width'(1);
        up_req <= 1'b0;
      end else if (up_ack) begin
        proto_err <= 1'b1;
      end else if (!up_req && has_room) begin
        up_req <= 1'b1;
      end
      dn_ack <= rd;
      if (rd) begin
        dn_dout <= rd_data;
        rd_ptr <= rd_ptr + addr_width'(1);
        count_out <= count_out + count_width'(1);
      end
      level <= (wr && !rd) ? level + (addr_width+1)'(1) :
               (!wr && rd) ? level - (addr_width+1)'(1) : level;
    end
  end
endmodule

// File: tb/tb_req_ack_fifo.sv
// tb_req_ack_fifo: directed self-checking bench for req_ack_fifo
module tb_req_ack_fifo;
  logic clk = 0, rst = 1;
  logic up_req, up_ack = 0, dn_req = 0, dn_ack;
  logic [31:0] up_din = 0, dn_dout, count_in, count_out;
  logic [3:0] level;
  logic full, empty, proto_err;
  logic prod_en = 0, inject = 0;
  logic [31:0] next_in = 0;
  logic [31:0] q[$];
  int n_writes = 0, n_reads = 0, errors = 0, checks = 0;

  req_ack_fifo dut (
    .clk(clk), .rst(rst),
    .up_req(up_req), .up_ack(up_ack), .up_din(up_din),
    .dn_req(dn_req), .dn_ack(dn_ack), .dn_dout(dn_dout),
    .level(level), .full(full), .empty(empty),
    .count_in(count_in), .count_out(count_out), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // producer: acks every visible request with an incrementing value; inject forces an unsolicited ack
  initial forever begin
    @(negedge clk);
    if (inject) begin
      up_ack = 1;
      up_din = 32'hdead_beef;
    end else if (prod_en && up_req) begin
      up_ack = 1;
      up_din = next_in;
      q.push_back(next_in);
      next_in++;
      n_writes++;
    end else begin
      up_ack = 0;
    end
  end

  // consumer monitor: every dn_ack must carry the oldest value handed to the buffer
  initial forever begin
    @(negedge clk);
    if (dn_ack) begin
      if (q.size() == 0) check("dn_spurious", 1, 0);
      else check("dn_dout", dn_dout, q.pop_front());
      n_reads++;
    end
  end

  initial begin
    int target;
    tick(3);
    check("rst_up_req", up_req, 0);
    check("rst_dn_ack", dn_ack, 0);
    check("rst_dn_dout", dn_dout, 0);
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count_in", count_in, 0);
    check("rst_count_out", count_out, 0);
    check("rst_proto_err", proto_err, 0);
    rst = 0;
    tick();
    check("idle_up_req", up_req, 1);
    tick(3);
    check("idle_dn_ack", dn_ack, 0);
    check("idle_empty", empty, 1);
    check("idle_level", level, 0);

    // fill with consumer stalled
    prod_en = 1;
    for (int i = 0; i < 60 && n_writes < 8; i++) tick();
    check("fill_wait", n_writes >= 8, 1);
    tick(4);
    check("fill_full", full, 1);
    check("fill_level", level, 8);
    check("fill_up_req", up_req, 0);
    check("fill_count_in", count_in, 8);
    check("fill_writes", n_writes, 8);
    prod_en = 0;

    // drain 0..7 in order
    dn_req = 1;
    for (int i = 0; i < 60 && n_reads < 8; i++) tick();
    check("drain_wait", n_reads >= 8, 1);
    dn_req = 0;
    tick(2);
    check("drain_level", level, 0);
    check("drain_empty", empty, 1);
    check("drain_count_out", count_out, 8);
    check("drain_up_req", up_req, 1);

    // free-running for 5000 items
    prod_en = 1;
    dn_req = 1;
    for (int i = 0; i < 30000 && n_reads < 5008; i++) tick();
    check("run_wait", n_reads >= 5008, 1);
    dn_req = 0;
    tick(2);
    check("run_count_out", count_out, 5008);
    check("run_proto_err", proto_err, 0);

    // refill to full, then inject an unsolicited ack
    for (int i = 0; i < 100 && (n_writes - n_reads) < 8; i++) tick();
    check("refill_wait", n_writes - n_reads, 8);
    tick(4);
    prod_en = 0;
    check("refill_full", full, 1);
    check("refill_up_req", up_req, 0);
    inject = 1;
    tick();
    inject = 0;
    tick(2);
    check("proto_err_set", proto_err, 1);
    check("proto_level", level, 8);
    check("proto_count_in", count_in, n_writes);
    tick(3);
    check("proto_sticky", proto_err, 1);

    // drain three to level 5, request left outstanding
    target = n_reads + 3;
    dn_req = 1;
    for (int i = 0; i < 40 && n_reads < target; i++) tick();
    check("part_wait", n_reads, target);
    dn_req = 0;
    tick(2);
    check("part_level", level, 5);
    check("part_up_req", up_req, 1);

    // reset mid-transfer with an ack arriving during rst
    rst = 1;
    prod_en = 1;
    tick();
    q.delete();
    check("mid_rst_level", level, 0);
    check("mid_rst_dn_ack", dn_ack, 0);
    check("mid_rst_count_in", count_in, 0);
    check("mid_rst_up_req", up_req, 0);
    tick();
    rst = 0;
    tick();
    check("post_rst_proto_err", proto_err, 0);
    check("post_rst_empty", empty, 1);
    target = n_reads + 4;
    dn_req = 1;
    for (int i = 0; i < 60 && n_reads < target; i++) tick();
    check("post_rst_wait", n_reads, target);
    dn_req = 0;
    tick(2);
    check("post_rst_count_out", count_out, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
